// File: rtl/riscv_isa_defines.sv
// Shared RV32I encoding definitions: instruction format codes, major opcodes,
// the canonical NOP and a signed-immediate range helper.
package riscv_isa_defines;

  typedef enum logic [2:0] {
    FMT_R     = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHIFT = 3'd6,
    FMT_RSVD  = 3'd7
  } fmt_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPCODE_LOAD     = 7'h03;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'h0F;
  localparam logic [6:0] OPCODE_OP_IMM   = 7'h13;
  localparam logic [6:0] OPCODE_AUIPC    = 7'h17;
  localparam logic [6:0] OPCODE_STORE    = 7'h23;
  localparam logic [6:0] OPCODE_OP       = 7'h33;
  localparam logic [6:0] OPCODE_LUI      = 7'h37;
  localparam logic [6:0] OPCODE_BRANCH   = 7'h63;
  localparam logic [6:0] OPCODE_JALR     = 7'h67;
  localparam logic [6:0] OPCODE_JAL      = 7'h6F;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'h73;

  // One buffered output word: the packed instruction and its range-error tag.
  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } enc_word_t;

  // True when imm is representable as an nbits-wide two's-complement value,
  // i.e. every bit from nbits-1 upward is a copy of the sign.
  function automatic logic fits_simm(input logic [31:0] imm, input int unsigned nbits);
    logic [31:0] hi;
    hi = 32'($signed(imm) >>> (nbits - 1));
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer: scatters the immediate into the format's
// bit positions and flags immediates that do not fit or are misaligned.
module instr_pack
  import riscv_isa_defines::*;
(
  input  logic [2:0]  i_fmt,
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [31:0] i_imm,
  output logic [31:0] o_instr,
  output logic        o_err
);

  fmt_e w_fmt;
  assign w_fmt = fmt_e'(i_fmt);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    o_instr = NOP_INSTR;
    o_err   = 1'b0;
    case (w_fmt)
      FMT_R: begin
        o_instr = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      end
      FMT_I: begin
        o_instr = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
        o_err   = !fits_simm(i_imm, 12);
      end
      FMT_SHIFT: begin
        o_instr = {i_funct7, i_imm[4:0], i_rs1, i_funct3, i_rd, i_opcode};
        o_err   = (i_imm[31:5] != '0);
      end
      FMT_S: begin
        o_instr = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
        o_err   = !fits_simm(i_imm, 12);
      end
      FMT_B: begin
        o_instr = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                   i_imm[4:1], i_imm[11], i_opcode};
        o_err   = i_imm[0] || !fits_simm(i_imm, 13);
      end
      FMT_U: begin
        o_instr = {i_imm[31:12], i_rd, i_opcode};
        o_err   = (i_imm[11:0] != '0);
      end
      FMT_J: begin
        o_instr = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
        o_err   = i_imm[0] || !fits_simm(i_imm, 21);
      end
      default: begin
        o_instr = NOP_INSTR;
        o_err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder: one-cycle packing into a two-entry
// output/skid buffer, with each word tagged by an auto-incrementing address.
module instr_encoder
  import riscv_isa_defines::*;
#(
  parameter int unsigned            ADDR_W     = 16,
  parameter logic [ADDR_W-1:0]      RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              err_sticky
);

  enc_word_t         w_enc;
  logic              w_accept;
  logic              w_pop;
  logic              w_out_free;
  logic              w_skid_load;
  logic              w_skid_valid_nxt;
  logic [ADDR_W-1:0] w_tag_addr;

  logic              r_in_ready;
  logic              r_out_valid;
  enc_word_t         r_out_word;
  logic [ADDR_W-1:0] r_out_addr;
  logic              r_skid_valid;
  enc_word_t         r_skid_word;
  logic [ADDR_W-1:0] r_skid_addr;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err_sticky;

  instr_pack u_pack (
    .i_fmt    (in_fmt),
    .i_opcode (in_opcode),
    .i_rd     (in_rd),
    .i_rs1    (in_rs1),
    .i_rs2    (in_rs2),
    .i_funct3 (in_funct3),
    .i_funct7 (in_funct7),
    .i_imm    (in_imm),
    .o_instr  (w_enc.instr),
    .o_err    (w_enc.err)
  );

  assign w_accept   = in_valid && r_in_ready;
  assign w_pop      = r_out_valid && out_ready;
  assign w_out_free = !r_out_valid || out_ready;
  assign w_tag_addr = addr_load ? addr_value : r_addr;

  // A new word lands in the skid register only when the output register is
  // still occupied after this edge (stalled, or refilled from the skid).
  assign w_skid_load      = w_accept && (!w_out_free || r_skid_valid);
  assign w_skid_valid_nxt = w_out_free ? (r_skid_valid && w_accept)
                                       : (r_skid_valid || w_accept);

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    if (rst) begin
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_word   <= '0;
      r_out_addr   <= RESET_ADDR;
      r_skid_valid <= 1'b0;
      r_addr       <= RESET_ADDR;
      r_err_sticky <= 1'b0;
    end else begin
      if (w_out_free) begin
        if (r_skid_valid) begin
          r_out_valid <= 1'b1;
          r_out_word  <= r_skid_word;
          r_out_addr  <= r_skid_addr;
        end else if (w_accept) begin
          r_out_valid <= 1'b1;
          r_out_word  <= w_enc;
          r_out_addr  <= w_tag_addr;
        end else begin
          r_out_valid <= 1'b0;
        end
      end
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= !w_skid_valid_nxt;
      r_addr       <= w_accept ? (w_tag_addr + ADDR_W'(4)) : w_tag_addr;
      r_err_sticky <= r_err_sticky | (w_pop && r_out_word.err);
    end
  end

  // NOTE: the skid payload has no reset; r_skid_valid alone decides whether
  // its contents mean anything, so clearing the data would buy nothing.
  always_ff @(posedge clk) begin
    if (w_skid_load) begin
      r_skid_word <= w_enc;
      r_skid_addr <= w_tag_addr;
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_instr  = r_out_word.instr;
  assign out_err    = r_out_word.err;
  assign out_addr   = r_out_addr;
  assign err_sticky = r_err_sticky;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed encodings, backpressure,
// address loading, mid-stream reset and a randomized scoreboard run.
module tb_instr_encoder;
  import riscv_isa_defines::*;

  localparam int unsigned ADDR_W     = 16;
  localparam logic [15:0] RESET_ADDR = 16'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        addr_load;
  logic [15:0] addr_value;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [15:0] out_addr;
  logic        out_err;
  logic        err_sticky;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(ADDR_W), .RESET_ADDR(RESET_ADDR)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_fmt     (in_fmt),
    .in_opcode  (in_opcode),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_funct3  (in_funct3),
    .in_funct7  (in_funct7),
    .in_imm     (in_imm),
    .addr_load  (addr_load),
    .addr_value (addr_value),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_addr   (out_addr),
    .out_err    (out_err),
    .err_sticky (err_sticky)
  );

  typedef struct {
    logic [31:0] instr;
    logic [15:0] addr;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] m_addr;
  bit          m_sticky;
  bit          m_rst_last;
  int          n_total = 0;
  int          n_bad   = 0;

  // Reference encoder built from the field-placement rules with shifts and masks.
  function automatic void model_encode(input logic [2:0] fmt, input logic [31:0] op,
      input logic [31:0] rd, input logic [31:0] rs1, input logic [31:0] rs2,
      input logic [31:0] f3, input logic [31:0] f7, input logic [31:0] imm,
      output logic [31:0] w, output logic e);
    int si;
    si = $signed(imm);
    e  = 1'b0;
    case (fmt)
      FMT_R: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      FMT_I: begin
        w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
        e = (si < -2048) || (si > 2047);
      end
      FMT_SHIFT: begin
        w = (f7 << 25) | ((imm & 32'h1F) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
        e = (si < 0) || (si > 31);
      end
      FMT_S: begin
        w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
          | ((imm & 32'h1F) << 7) | op;
        e = (si < -2048) || (si > 2047);
      end
      FMT_B: begin
        w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
          | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
          | (((imm >> 11) & 32'h1) << 7) | op;
        e = ((imm & 32'h1) != 0) || (si < -4096) || (si > 4094);
      end
      FMT_U: begin
        w = (imm & 32'hFFFFF000) | (rd << 7) | op;
        e = (imm & 32'hFFF) != 0;
      end
      FMT_J: begin
        w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
          | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | op;
        e = ((imm & 32'h1) != 0) || (si < -1048576) || (si > 1048574);
      end
      default: begin
        w = 32'h0000_0013;
        e = 1'b1;
      end
    endcase
  endfunction

  function automatic logic [31:0] rand_imm();
    int edge_imm [15] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, -4098,
                          1048574, -1048576, 1048576, -1048578, 31, 32, -1};
    case ($urandom_range(0, 5))
      0:       return $urandom;
      1:       return 32'(int'($urandom_range(0, 80)) - 40);
      2:       return 32'(edge_imm[$urandom_range(0, 14)]);
      3:       return $urandom & 32'hFFFFF000;
      4:       return 32'(int'($urandom_range(0, 8191)) - 4096);
      default: return 32'(int'($urandom_range(0, 2097151)) - 1048576);
    endcase
  endfunction

  task automatic set_req(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  // Called at a falling edge with inputs settled: scoreboards the outputs,
  // advances the model across the coming rising edge, then waits for the next fall.
  task automatic tick();
    bit          exp_rdy, acc, pop;
    exp_t        e;
    logic [31:0] w;
    logic        er;
    logic [15:0] tag;
    exp_rdy = !m_rst_last && (exp_q.size() < 2);
    n_total++;
    if (in_ready !== exp_rdy) begin
      n_bad++; $display("FAIL sb_in_ready: got %b want %b", in_ready, exp_rdy);
    end
    n_total++;
    if (out_valid !== (exp_q.size() > 0)) begin
      n_bad++; $display("FAIL sb_out_valid: got %b want %0d", out_valid, exp_q.size() > 0);
    end
    if (exp_q.size() > 0) begin
      n_total++;
      if (out_instr !== exp_q[0].instr) begin
        n_bad++; $display("FAIL sb_instr: got %h want %h", out_instr, exp_q[0].instr);
      end
      n_total++;
      if (out_addr !== exp_q[0].addr) begin
        n_bad++; $display("FAIL sb_addr: got %h want %h", out_addr, exp_q[0].addr);
      end
      n_total++;
      if (out_err !== exp_q[0].err) begin
        n_bad++; $display("FAIL sb_err: got %b want %b", out_err, exp_q[0].err);
      end
    end
    n_total++;
    if (err_sticky !== m_sticky) begin
      n_bad++; $display("FAIL sb_sticky: got %b want %b", err_sticky, m_sticky);
    end
    acc = in_valid && exp_rdy;
    pop = (exp_q.size() > 0) && out_ready;
    if (rst) begin
      exp_q.delete();
      m_addr = RESET_ADDR; m_sticky = 1'b0; m_rst_last = 1'b1;
    end else begin
      if (pop) begin
        m_sticky = m_sticky | exp_q[0].err;
        void'(exp_q.pop_front());
      end
      tag = addr_load ? addr_value : m_addr;
      if (acc) begin
        model_encode(in_fmt, 32'(in_opcode), 32'(in_rd), 32'(in_rs1), 32'(in_rs2),
                     32'(in_funct3), 32'(in_funct7), in_imm, w, er);
        e.instr = w; e.addr = tag; e.err = er;
        exp_q.push_back(e);
        m_addr = tag + 16'd4;
      end else begin
        m_addr = tag;
      end
      m_rst_last = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; addr_load = 1'b0; out_ready = 1'b0;
    rst = 1'b1; tick();
    rst = 1'b0; tick();
  endtask

  task automatic send_check(input string name, input logic [2:0] fmt, input logic [6:0] op,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
      input logic [31:0] x_instr, input logic x_err, input logic [15:0] x_addr);
    set_req(fmt, op, rd, rs1, rs2, f3, f7, imm);
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_total++;
    if (out_valid !== 1'b1) begin
      n_bad++; $display("FAIL %s valid: got %b want 1", name, out_valid);
    end
    n_total++;
    if (out_instr !== x_instr) begin
      n_bad++; $display("FAIL %s instr: got %h want %h", name, out_instr, x_instr);
    end
    n_total++;
    if (out_err !== x_err) begin
      n_bad++; $display("FAIL %s err: got %b want %b", name, out_err, x_err);
    end
    n_total++;
    if (out_addr !== x_addr) begin
      n_bad++; $display("FAIL %s addr: got %h want %h", name, out_addr, x_addr);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; addr_load = 1'b0; addr_value = '0;
    set_req(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_total++;
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_total++;
    if (out_instr !== 32'd0) begin n_bad++; $display("FAIL rst_out_instr: got %h want 0", out_instr); end
    n_total++;
    if (out_addr !== RESET_ADDR) begin n_bad++; $display("FAIL rst_out_addr: got %h want %h", out_addr, RESET_ADDR); end
    n_total++;
    if (out_err !== 1'b0) begin n_bad++; $display("FAIL rst_out_err: got %b want 0", out_err); end
    n_total++;
    if (err_sticky !== 1'b0) begin n_bad++; $display("FAIL rst_sticky: got %b want 0", err_sticky); end
    exp_q.delete();
    m_addr = RESET_ADDR; m_sticky = 1'b0; m_rst_last = 1'b1;
    rst = 1'b0;
    tick();
    n_total++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_encodings();
    do_reset();
    send_check("i_addi", FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF,
               32'hFFF00093, 1'b0, 16'h0000);
    do_reset();
    send_check("s_sw", FMT_S, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,
               32'h0020A423, 1'b0, 16'h0000);
    send_check("b_beq", FMT_B, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC,
               32'hFE000EE3, 1'b0, 16'h0004);
    do_reset();
    send_check("j_jal", FMT_J, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,
               32'h001000EF, 1'b0, 16'h0000);
    send_check("u_lui", FMT_U, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000,
               32'h123452B7, 1'b0, 16'h0004);
  endtask

  task automatic test_errors();
    do_reset();
    send_check("b_odd", FMT_B, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,
               32'h00000163, 1'b1, 16'h0000);
    n_total++;
    if (err_sticky !== 1'b1) begin n_bad++; $display("FAIL sticky_set: got %b want 1", err_sticky); end
    send_check("shift_32", FMT_SHIFT, 7'h13, 5'd1, 5'd2, 5'd0, 3'd1, 7'd0, 32'd32,
               32'h00011093, 1'b1, 16'h0004);
    send_check("r_sub", FMT_R, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hFFFF_FFFF,
               32'h402081B3, 1'b0, 16'h0008);
    send_check("rsvd", FMT_RSVD, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0,
               32'h00000013, 1'b1, 16'h000C);
    n_total++;
    if (err_sticky !== 1'b1) begin n_bad++; $display("FAIL sticky_hold: got %b want 1", err_sticky); end
    do_reset();
    n_total++;
    if (err_sticky !== 1'b0) begin n_bad++; $display("FAIL sticky_clear: got %b want 0", err_sticky); end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_addrs [3] = '{16'h0000, 16'h0004, 16'h0008};
    int  k;
    bit  acc_now;
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    set_req(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1); tick();
    set_req(FMT_I, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2); tick();
    n_total++;
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_low: got %b want 0", in_ready); end
    set_req(FMT_I, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    for (int c = 0; c < 3; c++) begin
      tick();
      n_total++;
      if (out_addr !== 16'h0000) begin n_bad++; $display("FAIL bp_stall_addr: got %h want 0000", out_addr); end
    end
    out_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 20 && k < 3; c++) begin
      if (out_valid === 1'b1) begin
        n_total++;
        if (out_addr !== exp_addrs[k]) begin
          n_bad++; $display("FAIL bp_drain_addr: got %h want %h", out_addr, exp_addrs[k]);
        end
        k++;
      end
      acc_now = in_valid && in_ready;
      tick();
      if (acc_now) in_valid = 1'b0;
    end
    n_total++;
    if (k != 3) begin n_bad++; $display("FAIL bp_drain_timeout: got %0d words want 3", k); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_addr_load();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    addr_load = 1'b1; addr_value = 16'h0100;
    set_req(FMT_I, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4); tick();
    addr_load = 1'b0;
    n_total++;
    if (out_addr !== 16'h0100) begin n_bad++; $display("FAIL load_addr0: got %h want 0100", out_addr); end
    set_req(FMT_I, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5); tick();
    in_valid = 1'b0;
    n_total++;
    if (out_addr !== 16'h0104) begin n_bad++; $display("FAIL load_addr1: got %h want 0104", out_addr); end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    set_req(FMT_I, 7'h13, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6); tick(); tick();
    in_valid = 1'b0; rst = 1'b1; tick();
    n_total++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
    rst = 1'b0; tick();
    n_total++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_ready: got %b want 1", in_ready); end
    out_ready = 1'b1; in_valid = 1'b1; tick();
    in_valid = 1'b0;
    n_total++;
    if (out_addr !== RESET_ADDR || out_valid !== 1'b1) begin
      n_bad++; $display("FAIL mid_rst_addr: got %h/%b want %h/1", out_addr, out_valid, RESET_ADDR);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 9) < 7);
      addr_load  = ($urandom_range(0, 31) == 0);
      addr_value = ($urandom_range(0, 3) == 0) ? 16'hFFF8 : (16'($urandom) & 16'hFFFC);
      set_req(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
              5'($urandom), 3'($urandom), 7'($urandom), rand_imm());
      tick();
    end
    in_valid = 1'b0; addr_load = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    n_total++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rand_drain: got %b want 0", out_valid); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_encodings();
    test_errors();
    test_backpressure();
    test_addr_load();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Encodes RISC-V RV32I instructions: packs opcode, register, funct and immediate fields into a 32-bit instruction word. This is the inverse of the core's immediate generator.
- Used by the boot/debug loader to build instruction-memory images at runtime.
- Streaming valid/ready in and out, 1-cycle latency, 2-entry output skid buffer.
- Checks immediate range and alignment, and tags each output word with its target instruction-memory address.

Parameters:
- ADDR_W, 16, width of the instruction-memory byte address tagged on each output word.
- RESET_ADDR, 0, address loaded into the address counter on reset.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept a request.
- in_fmt  in  3  format code: R/I/S/B/U/J/SHIFT (values in package).
- in_opcode  in  7  major opcode, copied to bits [6:0].
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_funct3  in  3  funct3 field.
- in_funct7  in  7  funct7 field (R and SHIFT formats).
- in_imm  in  32  signed byte-valued immediate (U format: full 32-bit value).
- addr_load  in  1  load the address counter from addr_value.
- addr_value  in  ADDR_W  new base address; must be word aligned.
- out_valid  out  1  encoded word available.
- out_ready  in  1  consumer accepts the word.
- out_instr  out  32  encoded instruction.
- out_addr  out  ADDR_W  target address of out_instr.
- out_err  out  1  word was encoded from an out-of-range or misaligned immediate.
- err_sticky  out  1  OR of all out_err values since reset.

Behaviour:
- Reset values:
  - out_valid=0, in_ready=0 during reset, 1 in the first cycle after reset.
  - out_instr=0, out_addr=RESET_ADDR, out_err=0, err_sticky=0.
  - Skid buffer emptied; address counter = RESET_ADDR.
  - Reset asserted mid-transfer discards all buffered words; nothing is replayed.
- Accept: a request is taken when in_valid && in_ready.
- Latency: the encoded word appears on out_* in the cycle after acceptance if the output register is free. Throughput is 1 word per cycle when out_ready=1.
- Buffering: 2 entries (output register plus skid register). in_ready is registered and equals !skid_full. Words leave in acceptance order.
- Encoding by in_fmt:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - SHIFT: {funct7, imm[4:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
  - Reserved fmt code: out_instr = 0x00000013 (NOP), out_err=1.
- Range checks set out_err=1 when violated. The word is still encoded with the truncated fields.
  - I/S: -2048 ≤ imm ≤ 2047.
  - B: imm[0]=0 and -4096 ≤ imm ≤ 4094.
  - J: imm[0]=0 and -2^20 ≤ imm ≤ 2^20-2.
  - U: imm[11:0]=0.
  - SHIFT: 0 ≤ imm ≤ 31.
  - R: never sets out_err.
- Address tagging:
  - The counter value is assigned to a word at acceptance; the counter then increments by 4, wrapping modulo 2^ADDR_W.
  - addr_load takes effect at the clock edge. If the same cycle also has an acceptance, that word gets addr_value and the counter becomes addr_value+4.
  - Words already buffered keep their assigned addresses.
- err_sticky sets when a word with out_err=1 completes an output transfer (out_valid && out_ready). Only reset clears it.
- Output signals are held stable while out_valid && !out_ready.

Decomposition:
- Shared package (riscv_isa_defines), holding:
  - FMT_R=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5, FMT_SHIFT=6; 7 is reserved.
  - The NOP constant 0x00000013.
  - The existing OPCODE_* constants.
- Sub-module instr_pack: purely combinational field packing plus range check. It outputs the 32-bit word and the err flag.
- The top level holds the skid buffer and the address counter.

Test Plan:
- FMT_I, opcode=0x13, rd=1, rs1=0, f3=0, imm=-1 → out_instr=0xFFF00093, out_err=0, out_addr=0 one cycle after accept.
- FMT_S, opcode=0x23, f3=2, rs1=1, rs2=2, imm=8 → 0x0020A423. Then FMT_B, opcode=0x63, rs1=rs2=0, f3=0, imm=-4 → 0xFE000EE3 with out_addr=4.
- FMT_J, opcode=0x6F, rd=1, imm=2048 → 0x001000EF. Then FMT_U, opcode=0x37, rd=5, imm=0x12345000 → 0x123452B7.
- FMT_B, imm=3 → out_err=1 and err_sticky=1 after transfer. FMT_SHIFT, imm=32 → out_err=1. FMT_R → out_err=0.
- Backpressure:
  - Stimulus: out_ready=0 with continuous in_valid.
  - in_ready falls after 2 accepts.
  - Releasing out_ready drains the words in order at addresses 0, 4, 8.
  - Output signals stay stable while stalled.
- addr_load=1, addr_value=0x0100 in the same cycle as an accept → that word gets out_addr=0x0100, the next word 0x0104. Reset mid-stream → out_valid=0 next cycle, the next word gets address RESET_ADDR.
